// File: rtl/branch_predict.sv
// Fetch-side direction/target predictor.
// Direct-mapped table of {valid, tag, target, 2-bit counter}. Fetch reads it
// combinationally. Execute trains it at the clock edge, and a registered
// flush/redirect pulse is raised one cycle after a mispredicted resolve.
module branch_predict #(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_fe,
  output logic            pred_taken_fe,
  output logic [XLEN-1:0] pred_target_fe,
  input  logic            upd_valid_ex,
  input  logic [XLEN-1:0] upd_pc_ex,
  input  logic            is_jump_ex,
  input  logic            jump_state_pre,
  input  logic [XLEN-1:0] target_ex,
  input  logic            pred_taken_ex,
  input  logic [XLEN-1:0] pred_target_ex,
  output logic            flush_req,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     branch_cnt,
  output logic [31:0]     miss_cnt
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = XLEN - IDX_BITS - 2;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic            flush_q, flush_d;
  logic [XLEN-1:0] redirect_q, redirect_d;
  logic [31:0]     branch_cnt_q, branch_cnt_d;
  logic [31:0]     miss_cnt_q, miss_cnt_d;

  logic [IDX_BITS-1:0] fe_idx, u_idx;
  logic [TAG_W-1:0]    fe_tag, u_tag;
  logic                fe_hit, u_hit, taken_ex, miss_ex;

  // Instruction-alignment bits never take part in indexing or tagging.
  logic unused_lsb;
  assign unused_lsb = ^{pc_fe[1:0], upd_pc_ex[1:0]};

  assign fe_idx = pc_fe[IDX_BITS+1:2];
  assign fe_tag = pc_fe[XLEN-1:IDX_BITS+2];
  assign u_idx  = upd_pc_ex[IDX_BITS+1:2];
  assign u_tag  = upd_pc_ex[XLEN-1:IDX_BITS+2];

  // Fetch lookup: reads the registered table, so a same-cycle update is not visible yet.
  always_comb begin
    fe_hit         = valid_q[fe_idx] && (tag_q[fe_idx] == fe_tag);
    pred_taken_fe  = fe_hit && ctr_q[fe_idx][1];
    pred_target_fe = pred_taken_fe ? target_q[fe_idx] : pc_fe + XLEN'(4);
  end

  // Resolve-side decode: jumps are always taken regardless of the comparator.
  always_comb begin
    taken_ex = is_jump_ex | jump_state_pre;
    u_hit    = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    miss_ex  = upd_valid_ex &&
               ((pred_taken_ex != taken_ex) || (taken_ex && (pred_target_ex != target_ex)));
  end

  // Next-state for the flush pulse, redirect address and saturating counters.
  always_comb begin
    flush_d      = miss_ex;
    redirect_d   = redirect_q;
    branch_cnt_d = branch_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (miss_ex) begin
      redirect_d = taken_ex ? target_ex : upd_pc_ex + XLEN'(4);
    end
    if (upd_valid_ex && (branch_cnt_q != 32'hFFFF_FFFF)) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
    end
    if (miss_ex && (miss_cnt_q != 32'hFFFF_FFFF)) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  // Table training; allocation on a taken miss overwrites whatever lives at that index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (upd_valid_ex) begin
      if (taken_ex) begin
        if (u_hit) begin
          ctr_q[u_idx]    <= (ctr_q[u_idx] == 2'b11) ? 2'b11 : ctr_q[u_idx] + 2'b01;
          target_q[u_idx] <= target_ex;
        end else begin
          valid_q[u_idx]  <= 1'b1;
          tag_q[u_idx]    <= u_tag;
          target_q[u_idx] <= target_ex;
          ctr_q[u_idx]    <= is_jump_ex ? 2'b11 : 2'b10;
        end
      end else if (u_hit) begin
        ctr_q[u_idx] <= (ctr_q[u_idx] == 2'b00) ? 2'b00 : ctr_q[u_idx] - 2'b01;
      end
    end
  end

  // Registered flush/redirect and statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_q      <= 1'b0;
      redirect_q   <= '0;
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      flush_q      <= flush_d;
      redirect_q   <= redirect_d;
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign flush_req   = flush_q;
  assign redirect_pc = redirect_q;
  assign branch_cnt  = branch_cnt_q;
  assign miss_cnt    = miss_cnt_q;

endmodule

// File: tb/tb_branch_predict.sv
// Bench for branch_predict: directed scenarios plus random traffic against a
// table model; flush pulses are checked by a separate scoreboard monitor.
module tb_branch_predict;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_fe;
  logic        pred_taken_fe;
  logic [31:0] pred_target_fe;
  logic        upd_valid_ex;
  logic [31:0] upd_pc_ex;
  logic        is_jump_ex;
  logic        jump_state_pre;
  logic [31:0] target_ex;
  logic        pred_taken_ex;
  logic [31:0] pred_target_ex;
  logic        flush_req;
  logic [31:0] redirect_pc;
  logic [31:0] branch_cnt;
  logic [31:0] miss_cnt;

  branch_predict dut (
    .clk            (clk),
    .rst            (rst),
    .pc_fe          (pc_fe),
    .pred_taken_fe  (pred_taken_fe),
    .pred_target_fe (pred_target_fe),
    .upd_valid_ex   (upd_valid_ex),
    .upd_pc_ex      (upd_pc_ex),
    .is_jump_ex     (is_jump_ex),
    .jump_state_pre (jump_state_pre),
    .target_ex      (target_ex),
    .pred_taken_ex  (pred_taken_ex),
    .pred_target_ex (pred_target_ex),
    .flush_req      (flush_req),
    .redirect_pc    (redirect_pc),
    .branch_cnt     (branch_cnt),
    .miss_cnt       (miss_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [31:0] rpc;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: one entry per index, prediction = "counter at least 2".
  bit          mv   [64];
  logic [31:0] mtag [64];
  logic [31:0] mtgt [64];
  int          mctr [64];
  longint      mbr, mmiss;

  function automatic int midx(logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic bit mhit(logic [31:0] pc);
    return mv[midx(pc)] && (mtag[midx(pc)] == (pc >> 8));
  endfunction

  function automatic bit mpred(logic [31:0] pc);
    return mhit(pc) && (mctr[midx(pc)] >= 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      mv[i] = 1'b0; mtag[i] = '0; mtgt[i] = '0; mctr[i] = 1;
    end
    mbr = 0; mmiss = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: drive, check fetch prediction and counters, predict the flush, train the model.
  task automatic step(input bit v, input logic [31:0] upc, input bit jmp, input bit st,
                      input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt,
                      input logic [31:0] fpc);
    bit tk, ms, h;
    int u;
    logic [31:0] pt;
    upd_valid_ex = v; upd_pc_ex = upc; is_jump_ex = jmp; jump_state_pre = st;
    target_ex = tgt; pred_taken_ex = ptk; pred_target_ex = ptgt; pc_fe = fpc;
    #2;
    pt = mpred(fpc) ? mtgt[midx(fpc)] : fpc + 32'd4;
    chk("pred_taken_fe", {31'b0, pred_taken_fe}, {31'b0, mpred(fpc)});
    chk("pred_target_fe", pred_target_fe, pt);
    chk("branch_cnt", branch_cnt, mbr[31:0]);
    chk("miss_cnt", miss_cnt, mmiss[31:0]);
    tk = jmp | st;
    ms = v && ((ptk != tk) || (tk && (ptgt != tgt)));
    if (ms) exp_q.push_back('{cyc + 1, tk ? tgt : upc + 32'd4});
    @(posedge clk);
    if (v) begin
      u = midx(upc);
      h = mhit(upc);
      if (tk) begin
        if (h) begin
          mctr[u] = (mctr[u] < 3) ? mctr[u] + 1 : 3;
          mtgt[u] = tgt;
        end else begin
          mv[u] = 1'b1; mtag[u] = upc >> 8; mtgt[u] = tgt; mctr[u] = jmp ? 3 : 2;
        end
      end else if (h) begin
        mctr[u] = (mctr[u] > 0) ? mctr[u] - 1 : 0;
      end
      if (mbr < 64'hFFFF_FFFF) mbr++;
      if (ms && mmiss < 64'hFFFF_FFFF) mmiss++;
    end
    @(negedge clk);
    upd_valid_ex = 1'b0;
  endtask

  // Monitor: each cycle flush_req must match the scoreboard, and redirect_pc the queued address.
  always @(negedge clk) begin
    bit e;
    if (!rst) begin
      e = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("flush_req", {31'b0, flush_req}, {31'b0, e});
      if (e && flush_req) chk("redirect_pc", redirect_pc, exp_q[0].rpc);
      while ((exp_q.size() > 0) && (exp_q[0].due <= cyc)) void'(exp_q.pop_front());
    end
  end

  logic [31:0] tgts [4];
  logic [31:0] upc, fpc, tgt, ptgt;
  bit          jmp, st, ptk;

  initial begin
    tgts[0] = 32'h40; tgts[1] = 32'h80; tgts[2] = 32'hC0; tgts[3] = 32'h100;
    rst = 1'b1;
    upd_valid_ex = 0; upd_pc_ex = 0; is_jump_ex = 0; jump_state_pre = 0;
    target_ex = 0; pred_taken_ex = 0; pred_target_ex = 0; pc_fe = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // T1 reset state
    step(0, 0, 0, 0, 0, 0, 0, 32'h100);
    // T2 allocate on taken miss
    step(1, 32'h100, 0, 1, 32'h80, 0, 32'h104, 32'h100);
    step(0, 0, 0, 0, 0, 0, 0, 32'h100);
    // T3 hysteresis: nt, t, t, nt x4, then a taken must not re-allocate
    step(1, 32'h100, 0, 0, 32'h80, 1, 32'h80, 32'h100);
    step(1, 32'h100, 0, 1, 32'h80, 0, 32'h104, 32'h100);
    step(1, 32'h100, 0, 1, 32'h80, 1, 32'h80, 32'h100);
    repeat (4) step(1, 32'h100, 0, 0, 32'h80, 1, 32'h80, 32'h100);
    step(1, 32'h100, 0, 1, 32'h80, 0, 32'h104, 32'h100);
    step(0, 0, 0, 0, 0, 0, 0, 32'h100);
    // T4 alias: same index, different tag evicts the old entry
    step(1, 32'h100, 1, 0, 32'h200, 0, 32'h104, 32'h100);
    step(1, 32'h200, 0, 1, 32'h300, 0, 32'h204, 32'h100);
    step(0, 0, 0, 0, 0, 0, 0, 32'h100);
    step(0, 0, 0, 0, 0, 0, 0, 32'h200);
    // T5 same-cycle update and fetch of one index
    step(1, 32'h140, 0, 1, 32'h44, 0, 32'h144, 32'h140);
    step(0, 0, 0, 0, 0, 0, 0, 32'h140);
    // Wrap of pc_fe + 4
    step(0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC);

    // Random traffic over a small PC pool so hits, aliases and retraining are frequent
    for (int n = 0; n < 400; n++) begin
      upc  = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
             | 32'($urandom_range(0, 3));
      fpc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC :
             (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
      jmp  = ($urandom_range(0, 4) == 0);
      st   = $urandom_range(0, 1) == 1;
      tgt  = tgts[$urandom_range(0, 3)];
      if ($urandom_range(0, 1) == 1) begin
        ptk  = mpred(upc);
        ptgt = ptk ? mtgt[midx(upc)] : upc + 32'd4;
      end else begin
        ptk  = $urandom_range(0, 1) == 1;
        ptgt = tgts[$urandom_range(0, 3)];
      end
      step($urandom_range(0, 3) != 0, upc, jmp, st, tgt, ptk, ptgt, fpc);
    end

    // T6 async reset while a flush pulse is showing
    step(1, 32'h100, 0, 1, 32'h80, 0, 32'h104, 32'h100);
    #1 rst = 1'b1;
    #1;
    chk("flush_req@rst", {31'b0, flush_req}, 32'd0);
    chk("redirect_pc@rst", redirect_pc, 32'd0);
    chk("branch_cnt@rst", branch_cnt, 32'd0);
    chk("miss_cnt@rst", miss_cnt, 32'd0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0, 32'h100);
    step(0, 0, 0, 0, 0, 0, 0, 32'h140);

    repeat (2) step(0, 0, 0, 0, 0, 0, 0, 32'h0);
    chk("pending_flushes", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
